// File: rtl/fifo_sr_reader.sv
// rtl/fifo_sr_reader.sv - round-robin consumer for a shared-RAM multi-flux FIFO with per-flux valid/ready outputs
module fifo_sr_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int FLUX       = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          en,
    input  logic [FLUX-1:0]                               fifo_empty,
    input  logic [DATA_WIDTH+$clog2(FLUX)-1:0]            fifo_dout,
    output logic [FLUX-1:0]                               fifo_read,
    output logic [FLUX-1:0]                               out_valid,
    output logic [FLUX*DATA_WIDTH-1:0]                    out_data,
    input  logic [FLUX-1:0]                               out_ready,
    output logic                                          tag_err,
    output logic [CNT_WIDTH-1:0]                          pop_cnt
);
    localparam int TAG_WIDTH = $clog2(FLUX);
    localparam int W         = DATA_WIDTH + TAG_WIDTH;

    logic [TAG_WIDTH-1:0] rr_ptr;
    logic [FLUX-1:0]      elig;
    logic                 grant_valid;
    logic [TAG_WIDTH-1:0] grant_idx;
    logic [TAG_WIDTH-1:0] cand;

    // A slot being drained this cycle counts as free, so it can be refilled without a bubble.
    assign elig = {FLUX{en}} & ~fifo_empty & (~out_valid | out_ready);

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = rr_ptr;
        for (int i = 0; i < FLUX; i++) begin
            if (!grant_valid && elig[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
            cand = (cand == TAG_WIDTH'(FLUX - 1)) ? '0 : cand + TAG_WIDTH'(1);
        end
    end

    assign fifo_read = (rst || !grant_valid) ? '0
                     : ({{(FLUX-1){1'b0}}, 1'b1} << grant_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= '0;
            out_data  <= '0;
            tag_err   <= 1'b0;
            pop_cnt   <= '0;
            rr_ptr    <= '0;
        end else begin
            for (int k = 0; k < FLUX; k++) begin
                if (fifo_read[k]) begin
                    out_data[k*DATA_WIDTH +: DATA_WIDTH] <= fifo_dout[DATA_WIDTH-1:0];
                    out_valid[k] <= 1'b1;
                end else if (out_valid[k] && out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
            if (grant_valid) begin
                rr_ptr  <= (grant_idx == TAG_WIDTH'(FLUX - 1)) ? '0 : grant_idx + TAG_WIDTH'(1);
                pop_cnt <= pop_cnt + CNT_WIDTH'(1);
                if (fifo_dout[W-1 -: TAG_WIDTH] != grant_idx)
                    tag_err <= 1'b1;
            end
        end
    end
endmodule
